// File: rtl/hamming_pkg.sv
// Shared types and the SECDED Hamming(16,11) encode function.
// hamming_enc16 is the single definition of the code. The engine uses it, and
// reference models can import it.
// Codeword bit k (k=1..15) is Hamming position k, and bit 0 is overall parity.
// That gives cw = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
package hamming_pkg;

  localparam int CW_W  = 16;
  localparam int MSG_W = 11;
  localparam int IDX_W = 7;   // covers NUM_MSG up to 127

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CALC,
    WR_LO,
    WR_HI,
    VF_LO,
    VF_HI,
    VF_CMP,
    FIN
  } enc_state_t;

  function automatic logic [CW_W-1:0] hamming_enc16(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = ^d[11:8] ^ d[4] ^ d[3] ^ d[2];
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = ^d ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

endpackage

// File: rtl/hamming_enc_engine.sv
// Sequential SECDED Hamming(16,11) encoder engine on the data-memory port.
// The engine reads NUM_MSG two-byte messages starting at SRC_BASE. It writes
// each 16-bit codeword, low byte first, starting at DST_BASE. A falling edge on
// start, seen while the engine is idle, launches a run. done stays high until
// the next launch.
// Optional feature: define ENC_VERIFY_EN to re-read each written codeword.
// Any mismatch sets the sticky verify_err flag. Without the macro,
// verify_err is tied to 0.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        run request; a 1->0 transition launches a run
//   done         run complete
//   mem_addr     data-memory byte address (registered)
//   mem_wr_en    byte write strobe (registered)
//   mem_wr_data  write byte (registered)
//   mem_rd_data  read byte; the memory returns it one cycle after mem_addr
//   verify_err   sticky readback mismatch flag
module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          verify_err
);

  enc_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             start_q;
  logic [7:0]       lo_byte;
  logic [CW_W-1:0]  cw;
  logic [CW_W-1:0]  cw_next;
  logic             last;

  // Outputs are registered, so every transition loads the address and
  // strobe that the destination state presents.
  function automatic logic [AW-1:0] byte_addr(input int base,
                                              input logic [IDX_W-1:0] i,
                                              input logic hi);
    return AW'(base + 2 * int'(i) + int'(hi));
  endfunction

  // The high byte arrives on mem_rd_data during CALC. Only its bits [2:0]
  // carry message data.
  assign cw_next = hamming_enc16({mem_rd_data[2:0], lo_byte});
  assign last    = (idx == IDX_W'(NUM_MSG - 1));

`ifdef ENC_VERIFY_EN
  logic [7:0] rb_lo;
  logic       verr;
  assign verify_err = verr;
`else
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      done        <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      start_q     <= 1'b0;
      lo_byte     <= '0;
      cw          <= '0;
`ifdef ENC_VERIFY_EN
      rb_lo       <= '0;
      verr        <= 1'b0;
`endif
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_q && !start) begin
            state     <= RD_LO;
            idx       <= '0;
            done      <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= byte_addr(SRC_BASE, IDX_W'(0), 1'b0);
`ifdef ENC_VERIFY_EN
            verr      <= 1'b0;
`endif
          end
        end
        RD_LO: begin
          state    <= RD_HI;
          mem_addr <= byte_addr(SRC_BASE, idx, 1'b1);
        end
        RD_HI: begin
          lo_byte <= mem_rd_data;
          state   <= CALC;
        end
        CALC: begin
          cw          <= cw_next;
          state       <= WR_LO;
          mem_wr_en   <= 1'b1;
          mem_addr    <= byte_addr(DST_BASE, idx, 1'b0);
          mem_wr_data <= cw_next[7:0];
        end
        WR_LO: begin
          state       <= WR_HI;
          mem_wr_en   <= 1'b1;
          mem_addr    <= byte_addr(DST_BASE, idx, 1'b1);
          mem_wr_data <= cw[15:8];
        end
        WR_HI: begin
          mem_wr_en <= 1'b0;
`ifdef ENC_VERIFY_EN
          state     <= VF_LO;
          mem_addr  <= byte_addr(DST_BASE, idx, 1'b0);
`else
          if (last) begin
            state <= FIN;
          end else begin
            idx      <= idx + IDX_W'(1);
            state    <= RD_LO;
            mem_addr <= byte_addr(SRC_BASE, idx + IDX_W'(1), 1'b0);
          end
`endif
        end
`ifdef ENC_VERIFY_EN
        VF_LO: begin
          state    <= VF_HI;
          mem_addr <= byte_addr(DST_BASE, idx, 1'b1);
        end
        VF_HI: begin
          rb_lo <= mem_rd_data;
          state <= VF_CMP;
        end
        VF_CMP: begin
          if ({mem_rd_data, rb_lo} != cw) verr <= 1'b1;
          if (last) begin
            state <= FIN;
          end else begin
            idx      <= idx + IDX_W'(1);
            state    <= RD_LO;
            mem_addr <= byte_addr(SRC_BASE, idx + IDX_W'(1), 1'b0);
          end
        end
`endif
        FIN: begin
          done      <= 1'b1;
          mem_wr_en <= 1'b0;
          if (start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Directed bench for hamming_enc_engine. It covers hand-computed codewords,
// random messages with junk in the high byte, a start pulse while busy, an
// abort by reset in mid-run, and the readback check when ENC_VERIFY_EN is
// defined.
module tb_hamming_enc_engine;
  import hamming_pkg::*;

  localparam int N   = 15;
  localparam int SRC = 0;
  localparam int DST = 30;
`ifdef ENC_VERIFY_EN
  localparam int CPM = 8;
`else
  localparam int CPM = 5;
`endif
  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic       verify_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hamming_enc_engine #(.NUM_MSG(N), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .verify_err(verify_err)
  );

  // Synchronous-read byte memory. It has a bench load port, a write counter,
  // and an optional corruption of the byte at DST+5.
  logic [7:0] mem [0:255];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [7:0] tb_data = '0;
  logic       cnt_clr = 1'b0;
  logic       corrupt = 1'b0;
  int         wr_cnt = 0;

  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_wr_en)
      mem[mem_addr] <= (corrupt && mem_addr == 8'(DST + 5)) ? ~mem_wr_data : mem_wr_data;
    if (cnt_clr) wr_cnt <= 0;
    else if (mem_wr_en) wr_cnt <= wr_cnt + 1;
  end

  logic [10:0] msgs [N];
  logic [7:0]  hib  [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent syndrome decoder. A clean codeword yields {5'b0, d}.
  function automatic logic [15:0] dec(input logic [15:0] c);
    logic [3:0] s;
    s = '0;
    for (int k = 1; k < 16; k++) if (c[k]) s = s ^ 4'(k);
    return {s, ^c, c[15:9], c[7:5], c[3]};
  endfunction

  task automatic poke(input int a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = 8'(a); tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) begin
      poke(SRC + 2 * i, msgs[i][7:0]);
      poke(SRC + 2 * i + 1, hib[i]);
    end
    for (int a = DST; a < DST + 2 * N; a++) poke(a, 8'hAA);
  endtask

  // Ends #1 after the edge that samples start low.
  task automatic launch();
    @(negedge clk); start = 1'b1; cnt_clr = 1'b1;
    @(negedge clk); start = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int pulse_at, output int cyc);
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == pulse_at) start = 1'b1;
      else if (cyc == pulse_at + 1) start = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] cw;
    for (int i = 0; i < N; i++) begin
      cw = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
      check($sformatf("%s_cw%0d", tag, i), 32'(cw), 32'(hamming_enc16(msgs[i])));
      check($sformatf("%s_dec%0d", tag, i), 32'(dec(cw)), 32'({5'b0, msgs[i]}));
    end
  endtask

  initial begin
    int cyc;

    // Reset state
    #2;
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wr_data), 0);
    check("rst_verr", 32'(verify_err), 0);
    @(negedge clk); reset = 1'b1;

    // Directed vectors
    for (int i = 0; i < N; i++) begin msgs[i] = 11'h000; hib[i] = 8'h00; end
    msgs[1] = 11'h7FF; hib[1] = 8'h07;
    msgs[2] = 11'h001; hib[2] = 8'h00;
    msgs[3] = 11'h400; hib[3] = 8'h04;
    load();
    launch();
    wait_done(-10, cyc);
    check("dir_done_cyc", 32'(cyc), 32'(CPM * N + 1));
    check("dir_wr_cnt", 32'(wr_cnt), 2 * N);
    check("dir_b30", 32'(mem[30]), 32'h00);
    check("dir_b31", 32'(mem[31]), 32'h00);
    check("dir_b32", 32'(mem[32]), 32'hFF);
    check("dir_b33", 32'(mem[33]), 32'hFF);
    check("dir_b34", 32'(mem[34]), 32'h0F);
    check("dir_b35", 32'(mem[35]), 32'h00);
    check("dir_b36", 32'(mem[36]), 32'h17);
    check("dir_b37", 32'(mem[37]), 32'h81);
    check("dir_b58", 32'(mem[58]), 32'h00);
    check("dir_b59", 32'(mem[59]), 32'h00);
    check("dir_verr", 32'(verify_err), 0);

    // Random messages with junk in the high byte; start is pulsed mid-run
    for (int i = 0; i < N; i++) begin
      hib[i]  = 8'($urandom) | 8'h08;
      msgs[i] = {hib[i][2:0], 8'($urandom)};
    end
    load();
    launch();
    wait_done(30, cyc);
    check("rnd_done_cyc", 32'(cyc), 32'(CPM * N + 1));
    check("rnd_wr_cnt", 32'(wr_cnt), 2 * N);
    check_all("rnd");

    // Reset at cycle 20 aborts asynchronously
    for (int a = DST; a < DST + 2 * N; a++) poke(a, 8'hAA);
    launch();
    repeat (20) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_done", 32'(done), 0);
    check("abort_wr_en", 32'(mem_wr_en), 0);
    check("abort_addr", 32'(mem_addr), 0);
    check("abort_wdata", 32'(mem_wr_data), 0);
    check("abort_verr", 32'(verify_err), 0);
    check("abort_kept_b30", 32'(mem[30]), 32'(hamming_enc16(msgs[0]) & 16'h00FF));
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // start held low after reset does not launch a run
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_wr_cnt", 32'(wr_cnt), 0);
    check("idle_done", 32'(done), 0);
    check("idle_addr", 32'(mem_addr), 0);

    // Full rerun after the abort
    for (int a = DST; a < DST + 2 * N; a++) poke(a, 8'hAA);
    launch();
    wait_done(-10, cyc);
    check("rerun_done_cyc", 32'(cyc), 32'(CPM * N + 1));
    check("rerun_wr_cnt", 32'(wr_cnt), 2 * N);
    check_all("rerun");

`ifdef ENC_VERIFY_EN
    // Corrupted readback sets verify_err; the next clean run clears it
    corrupt = 1'b1;
    launch();
    wait_done(-10, cyc);
    check("vf_done_cyc", 32'(cyc), 32'(CPM * N + 1));
    check("vf_err_set", 32'(verify_err), 1);
    corrupt = 1'b0;
    launch();
    check("vf_err_clr_launch", 32'(verify_err), 0);
    wait_done(-10, cyc);
    check("vf_err_clean", 32'(verify_err), 0);
    check_all("vf_clean");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
